i2c_line_conditioner: RTL



---
 rtl/i2c_cond_pkg.sv | 19 +
 rtl/i2c_line_conditioner_if.sv | 27 ++
 rtl/i2c_glitch_filter.sv | 50 +++++
 rtl/i2c_line_conditioner.sv | 127 ++++++++++++
 4 files changed

// File: rtl/i2c_cond_pkg.sv
// Shared constants, types and width helper for the I2C line conditioner.
// The optional SCL-low timeout is built only when I2C_COND_TIMEOUT_EN is defined.
package i2c_cond_pkg;

    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned FILT_LEN_DEF    = 3;
    localparam int unsigned TIMEOUT_CYC_DEF = 4096;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_BUSY = 1'b1
    } bus_state_e;

    // Bits needed to hold a count of 0..max_count.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/i2c_line_conditioner_if.sv
// Bus-side signal bundle of the I2C line conditioner (raw lines in, clean levels/strobes out).
// The timeout member is only driven non-zero when I2C_COND_TIMEOUT_EN is defined.
interface i2c_line_conditioner_if;

    logic ena;
    logic scl_i;
    logic sda_i;
    logic scl_f;
    logic sda_f;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic bus_busy;
    logic timeout;

    modport master (
        output ena, scl_i, sda_i,
        input  scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, timeout
    );

    modport slave (
        input  ena, scl_i, sda_i,
        output scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, timeout
    );

endinterface

// File: rtl/i2c_glitch_filter.sv
// One I2C line: flop synchroniser followed by a stable-count glitch filter.
// Used for both SCL and SDA; unaffected by I2C_COND_TIMEOUT_EN.
module i2c_glitch_filter
    import i2c_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned FILT_LEN    = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic line_raw,
    output logic line_f
);

    localparam int unsigned     CW   = cnt_width(FILT_LEN);
    localparam logic [CW-1:0]   LAST = CW'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line_s;
    logic [CW-1:0]          cnt_q;

    // Synchroniser keeps shifting even while disabled; it presets high so the bus reads idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_raw};
        end
    end

    assign line_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            line_f <= 1'b1;
        end else if (ena) begin
            if (line_s == line_f) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                cnt_q  <= '0;
                line_f <= ~line_f;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_line_conditioner.sv
// I2C front end: filtered SCL/SDA, SCL edge strobes, START/STOP detection and bus-busy tracking.
// Define I2C_COND_TIMEOUT_EN to build the SCL-stuck-low timeout; otherwise timeout is tied 0.
module i2c_line_conditioner
    import i2c_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned FILT_LEN    = FILT_LEN_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    i2c_line_conditioner_if.slave  bus
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILT_LEN < 1 || FILT_LEN > 15 || TIMEOUT_CYC < 1)
    begin : g_param_check
        $error("i2c_line_conditioner: parameter out of legal range");
    end

    logic       scl_f, sda_f;
    logic       p_scl, p_sda;
    logic       rise_c, fall_c, start_c, stop_c;
    logic       rise_q, fall_q, start_q, stop_q;
    logic       timeout_q;
    bus_state_e state_q, state_d;

    i2c_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_scl_filt (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (bus.ena),
        .line_raw (bus.scl_i),
        .line_f   (scl_f)
    );

    i2c_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_sda_filt (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (bus.ena),
        .line_raw (bus.sda_i),
        .line_f   (sda_f)
    );

    // Requiring SCL high in both cycles rejects START/STOP when SCL and SDA move together.
    always_comb begin
        rise_c  = bus.ena && scl_f && !p_scl;
        fall_c  = bus.ena && !scl_f && p_scl;
        start_c = bus.ena && p_sda && !sda_f && p_scl && scl_f;
        stop_c  = bus.ena && !p_sda && sda_f && p_scl && scl_f;
    end

    // p_x tracks x_f every cycle; x_f is frozen while disabled, so re-enabling sees no edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_scl   <= 1'b1;
            p_sda   <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            p_scl   <= scl_f;
            p_sda   <= sda_f;
            rise_q  <= rise_c;
            fall_q  <= fall_c;
            start_q <= start_c;
            stop_q  <= stop_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BUS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_c) begin
            state_d = BUS_BUSY;
        end else if (stop_c || timeout_q) begin
            state_d = BUS_IDLE;
        end
    end

`ifdef I2C_COND_TIMEOUT_EN
    localparam int unsigned   TW     = cnt_width(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC);

    logic [TW-1:0] to_cnt_q;

    // Pulse only on the step into saturation; the saturated count suppresses repeats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (state_q != BUS_BUSY || scl_f) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q != TO_MAX) begin
                to_cnt_q  <= to_cnt_q + TW'(1);
                timeout_q <= (to_cnt_q == TO_MAX - TW'(1));
            end
        end
    end
`else
    assign timeout_q = 1'b0;
`endif

    assign bus.scl_f     = scl_f;
    assign bus.sda_f     = sda_f;
    assign bus.scl_rise  = rise_q  & bus.ena;
    assign bus.scl_fall  = fall_q  & bus.ena;
    assign bus.start_det = start_q & bus.ena;
    assign bus.stop_det  = stop_q  & bus.ena;
    assign bus.bus_busy  = (state_q == BUS_BUSY);
    assign bus.timeout   = timeout_q;

endmodule
